// File: rtl/pc_fetch_unit.sv
// Fetch-side program counter with prioritised next-PC selection, pending redirect and EPC.
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirect targets trap to the exception vector.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [31:0]       EXC_VECTOR = 32'h0000_0180
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              stall_i,
  input  logic              imem_ready_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic              exception_i,
  input  logic [ADDR_W-1:0] exc_pc_i,
  input  logic              eret_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              pending_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] EXC_PC     = ADDR_W'(EXC_VECTOR);
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(32'h0FFF_FFFF);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(3);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pend_tgt;
  logic              pend;
  logic              req;
  logic              misalign;

  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] raw_tgt;
  logic [ADDR_W-1:0] live_tgt;
  logic              live_vld;
  logic              misal;
  logic              advance;

  assign pc_plus4_o = pc + ADDR_W'(4);
  assign advance    = (state == RUN) && imem_ready_i && !stall_i;

  // Jump keeps the region bits of the link address and replaces the low 28 bits.
  assign jump_tgt = (pc_plus4_o & ~LOW28_MASK) | ADDR_W'({jump_index_i, 2'b00});

  // Non-exception redirect sources in fixed priority order.
  always_comb begin
    live_vld = 1'b0;
    raw_tgt  = branch_target_i;
    if (eret_i) begin
      live_vld = 1'b1;
      raw_tgt  = epc;
    end else if (jr_i) begin
      live_vld = 1'b1;
      raw_tgt  = jr_target_i;
    end else if (jump_i) begin
      live_vld = 1'b1;
      raw_tgt  = jump_tgt;
    end else if (branch_taken_i) begin
      live_vld = 1'b1;
      raw_tgt  = branch_target_i;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign live_tgt = raw_tgt;
  assign misal    = live_vld && ((raw_tgt & ALIGN_MASK) != '0);
`else
  assign live_tgt = raw_tgt & ~ALIGN_MASK;
  assign misal    = 1'b0;
`endif

  // State machine and all registered fetch state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      epc      <= '0;
      pend_tgt <= '0;
      pend     <= 1'b0;
      req      <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      unique case (state)
        BOOT: begin
          state <= RUN;
          req   <= 1'b1;
        end
        RUN: begin
          if (exception_i) begin
            pc   <= EXC_PC;
            epc  <= exc_pc_i;
            pend <= 1'b0;
          end else begin
            if (misal) begin
              // A misaligned target traps instead of being applied or latched.
              pc       <= EXC_PC;
              epc      <= live_tgt;
              misalign <= 1'b1;
              pend     <= 1'b0;
            end else if (advance) begin
              if (live_vld)  pc <= live_tgt;
              else if (pend) pc <= pend_tgt;
              else           pc <= pc_plus4_o;
              pend <= 1'b0;
            end else if (live_vld) begin
              pend_tgt <= live_tgt;
              pend     <= 1'b1;
            end
            if (halt_i) begin
              state <= HALT;
              req   <= 1'b0;
            end
          end
        end
        HALT: begin
          if (exception_i) begin
            state <= RUN;
            req   <= 1'b1;
            pc    <= EXC_PC;
            epc   <= exc_pc_i;
            pend  <= 1'b0;
          end
        end
        default: begin
          state <= BOOT;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o       = pc;
  assign epc_o      = epc;
  assign pending_o  = pend;
  assign imem_req_o = req;
  assign misalign_o = misalign;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter and next-PC selection unit; generalises the single-register PC into a fetch-side block.
- Holds the fetch PC and drives the instruction-memory request/ready handshake.
- Selects the next PC from sequential, branch, jump, jump-register, exception and ERET sources by fixed priority.
- Latches redirects that arrive while fetch is blocked, keeps EPC, and sits between the pipeline control logic and instruction memory.

Parameters:
- ADDR_W, 32, PC/address width; must be >= 28.
- RESET_PC, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, exception entry address (truncated to ADDR_W).

Ports:
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- stall_i  in  1  pipeline stall; blocks PC advance
- imem_ready_i  in  1  instruction memory accepted/returned current fetch
- branch_taken_i  in  1  conditional branch resolved taken
- branch_target_i  in  ADDR_W  branch target
- jump_i  in  1  J/JAL
- jump_index_i  in  26  instruction index field
- jr_i  in  1  JR/JALR
- jr_target_i  in  ADDR_W  register target
- exception_i  in  1  exception request
- exc_pc_i  in  ADDR_W  PC of faulting instruction
- eret_i  in  1  return from exception
- halt_i  in  1  enter HALT
- pc_o  out  ADDR_W  current fetch PC
- pc_plus4_o  out  ADDR_W  pc_o + 4 (combinational, wraps modulo 2^ADDR_W); link value, no delay slot
- imem_req_o  out  1  fetch request valid
- epc_o  out  ADDR_W  exception PC register
- pending_o  out  1  a redirect is latched and not yet applied
- misalign_o  out  1  1-cycle pulse, see Optional Feature

Behaviour:
- Reset (async, resetN low): pc_o=RESET_PC, epc_o=0, imem_req_o=0, pending_o=0, misalign_o=0, state=BOOT.
- States:
  - BOOT: imem_req_o=0; goes to RUN unconditionally after 1 cycle.
  - RUN: imem_req_o=1.
  - HALT: imem_req_o=0; PC frozen.
- Transitions:
  - RUN->HALT on halt_i, unless exception_i is high the same cycle.
  - HALT->RUN only on exception_i; pc_o<=EXC_VECTOR.
  - All other inputs are ignored in HALT.
- advance = (state==RUN) && imem_ready_i && !stall_i.
- Live redirect priority, highest first:
  1. exception_i: target EXC_VECTOR.
  2. eret_i: target epc_o.
  3. jr_i: target jr_target_i.
  4. jump_i: target {pc_plus4_o[ADDR_W-1:28], jump_index_i, 2'b00}.
  5. branch_taken_i: target branch_target_i.
- exception_i in any state except BOOT: epc_o<=exc_pc_i that cycle, independent of advance.
- On advance:
  - pc_o <= live redirect target if any;
  - else the pending target if pending_o;
  - else pc_plus4_o.
  - pending_o clears on advance.
- No advance but a live redirect present: latch its target into the pending register and set pending_o; a newer redirect overwrites an older pending one.
- Exception ignores advance: pc_o<=EXC_VECTOR and pending_o cleared in the same cycle, even when stalled or not ready.
- Latency: PC update occurs the clock edge after advance; a redirect takes effect on the first advance at or after its assertion.
- Reset mid-operation: all state, including the pending register and EPC, returns to reset values immediately.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: a selected non-exception target with bits[1:0]!=0 is not loaded. Instead, in the cycle it would be applied (advance, or latching into pending):
  - pc_o<=EXC_VECTOR;
  - epc_o<=the offending target;
  - misalign_o pulses 1 cycle;
  - pending_o cleared.
- Undefined: bits[1:0] of every target are forced to 0; misalign_o tied 0.

Test Plan:
- Reset release, imem_ready_i=1, no redirects -> BOOT 1 cycle with req=0, then pc_o 0,4,8,12 on successive cycles.
- pc_o=0x100, branch_taken_i=1, target 0x200, stall_i=1 for 3 cycles -> pending_o=1, pc_o stays 0x100; first unstalled edge gives pc_o=0x200, pending_o=0.
- pc_o=0x1000_0040, jump_i=1, jump_index_i=26'h10 -> pc_o=0x1000_0040.
- jr_i (0x300) and branch_taken_i (0x400) in the same cycle -> pc_o=0x300. With exception_i also set, exc_pc_i=0x80 -> pc_o=EXC_VECTOR, epc_o=0x80.
- Exception with imem_ready_i=0 -> pc_o=0x180 next edge. Later eret_i with advance -> pc_o=0x80.
- halt_i -> imem_req_o=0, PC frozen despite branch inputs; exception_i -> pc_o=0x180, RUN. With PC_ALIGN_CHECK_EN, jr_target_i=0x302 -> misalign_o pulse, epc_o=0x302, pc_o=0x180.
